miriscv_mem_arbiter: RTL and testbench

Shares one memory port between the fetch stage (read-only instruction requests) and the LSU (data requests), so the core can run from a single-port unified memory.
- Selects one requester per cycle and forwards it downstream.
- Records the owner of each accepted transaction in an in-order routing FIFO, and steers each returned mem_rvalid_i/mem_rdata_i to that owner.
- Data has priority by default; a starvation counter guarantees fetch progress.

---
 rtl/miriscv_arb_pkg.sv | 10 +
 rtl/miriscv_arb_route_fifo.sv | 64 ++++++
 rtl/miriscv_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_miriscv_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miriscv_arb_pkg.sv
// Shared types and defaults for the fetch/LSU memory arbiter.
package miriscv_arb_pkg;

  typedef enum logic {ARB_INSTR = 1'b0, ARB_DATA = 1'b1} arb_master_e;

  localparam int unsigned ARB_OUTSTANDING_DEFAULT  = 2;
  localparam int unsigned ARB_STARVE_LIMIT_DEFAULT = 4;
  localparam int unsigned ARB_XLEN_DEFAULT         = 32;

endpackage

// File: rtl/miriscv_arb_route_fifo.sv
// In-order owner FIFO: one arb_master_e entry per accepted, not yet answered transaction.
module miriscv_arb_route_fifo
  import miriscv_arb_pkg::*;
#(
  parameter int unsigned DEPTH = ARB_OUTSTANDING_DEFAULT
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        push_i,
  input  arb_master_e push_id_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        empty_o,
  output arb_master_e head_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] slot_q, slot_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign head_o  = arb_master_e'(slot_q[rd_ptr_q]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      slot_d[wr_ptr_q] = push_id_i;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
    if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      slot_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// Fetch/LSU arbiter onto one memory port, with in-order response routing.
// MIRISCV_ARB_RR_EN selects round-robin; otherwise data priority with a fetch starvation guard.
module miriscv_mem_arbiter
  import miriscv_arb_pkg::*;
#(
  parameter int unsigned OUTSTANDING  = ARB_OUTSTANDING_DEFAULT,
  parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT_DEFAULT,
  parameter int unsigned XLEN         = ARB_XLEN_DEFAULT
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              instr_req_i,
  input  logic [XLEN-1:0]   instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [XLEN-1:0]   instr_rdata_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [XLEN/8-1:0] data_be_i,
  input  logic [XLEN-1:0]   data_addr_i,
  input  logic [XLEN-1:0]   data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [XLEN-1:0]   data_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              arb_err_o
);

  logic        fifo_full, fifo_empty, grant, pop;
  logic        arb_err_q, arb_err_d;
  arb_master_e winner, head;

  // Issue is gated by the registered fill level only, so rvalid never reaches mem_req_o.
  assign mem_req_o = (instr_req_i | data_req_i) & ~fifo_full;
  assign grant     = mem_req_o & mem_gnt_i;

`ifdef MIRISCV_ARB_RR_EN
  arb_master_e last_q, last_d;

  always_comb begin
    winner = data_req_i ? ARB_DATA : ARB_INSTR;
    if (instr_req_i && data_req_i) winner = (last_q == ARB_INSTR) ? ARB_DATA : ARB_INSTR;
    last_d = grant ? winner : last_q;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) last_q <= ARB_INSTR;
    else          last_q <= last_d;
  end
`else
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    winner = (instr_req_i && (!data_req_i || starve_cnt_q == SW'(STARVE_LIMIT))) ?
             ARB_INSTR : ARB_DATA;
    starve_cnt_d = starve_cnt_q;
    if (!instr_req_i || (grant && winner == ARB_INSTR)) starve_cnt_d = '0;
    else if (grant && starve_cnt_q != SW'(STARVE_LIMIT)) starve_cnt_d = starve_cnt_q + SW'(1);
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) starve_cnt_q <= '0;
    else          starve_cnt_q <= starve_cnt_d;
  end
`endif

  assign instr_gnt_o = grant & (winner == ARB_INSTR);
  assign data_gnt_o  = grant & (winner == ARB_DATA);

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      if (winner == ARB_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o   = '1;
        mem_addr_o = instr_addr_i;
      end
    end
  end

  miriscv_arb_route_fifo #(.DEPTH(OUTSTANDING)) u_route_fifo (
    .clk_i     (clk_i),
    .arstn_i   (arstn_i),
    .push_i    (grant),
    .push_id_i (winner),
    .pop_i     (pop),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_o    (head)
  );

  assign pop            = mem_rvalid_i & ~fifo_empty;
  assign instr_rvalid_o = pop & (head == ARB_INSTR);
  assign data_rvalid_o  = pop & (head == ARB_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
  assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;

  // A response with nothing outstanding is dropped and flagged until reset.
  assign arb_err_d = arb_err_q | (mem_rvalid_i & fifo_empty);
  assign arb_err_o = arb_err_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) arb_err_q <= 1'b0;
    else          arb_err_q <= arb_err_d;
  end

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Self-checking bench for miriscv_mem_arbiter: vector table, response scoreboard, corner sequences.
module tb_miriscv_mem_arbiter;
  import miriscv_arb_pkg::*;

  localparam int XLEN = 32;

  logic              clk_i = 1'b0;
  logic              arstn_i = 1'b0;
  logic              instr_req_i, instr_gnt_o, instr_rvalid_o;
  logic [XLEN-1:0]   instr_addr_i, instr_rdata_o;
  logic              data_req_i, data_we_i, data_gnt_o, data_rvalid_o;
  logic [XLEN/8-1:0] data_be_i, mem_be_o;
  logic [XLEN-1:0]   data_addr_i, data_wdata_i, data_rdata_o;
  logic              mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, arb_err_o;
  logic [XLEN-1:0]   mem_addr_o, mem_wdata_o, mem_rdata_i;

  miriscv_mem_arbiter #(.OUTSTANDING(2), .STARVE_LIMIT(4), .XLEN(XLEN)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .arb_err_o(arb_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    arb_master_e owner;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq, dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr, dwdata;
    logic        mgnt;
    logic        e_req;
    arb_master_e e_win;
    logic        e_gnt;
  } vec_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        auto_rsp = 1'b0;
  arb_master_e rr_last = ARB_INSTR;

  function automatic logic [31:0] rsp_fn(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input arb_master_e o, input logic [31:0] d);
    exp_t e;
    e.owner = o;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic drive_idle();
    instr_req_i = 0; instr_addr_i = 0; data_req_i = 0; data_we_i = 0;
    data_be_i = 0; data_addr_i = 0; data_wdata_i = 0; mem_gnt_i = 0;
  endtask

  task automatic next();
    @(posedge clk_i); #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  function automatic logic [159:0] all_outs();
    return {instr_gnt_o, instr_rvalid_o, instr_rdata_o, data_gnt_o, data_rvalid_o, data_rdata_o,
            mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, arb_err_o};
  endfunction

  // Memory model: answers every accepted request one cycle later with rsp_fn(addr).
  always @(posedge clk_i) begin
    if (auto_rsp) begin
      logic        g;
      logic [31:0] a;
      g = mem_req_o && mem_gnt_i;
      a = mem_addr_o;
      #1;
      mem_rvalid_i = g;
      mem_rdata_i  = g ? rsp_fn(a) : 32'h0;
    end
  end

  // Scoreboard: every routed response must match the oldest expected owner/data.
  always @(negedge clk_i) begin : sb_check
    exp_t e;
    if (instr_rvalid_o || data_rvalid_o) begin
      if (exp_q.size() == 0)
        chk("rsp_unexpected", {instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o}, '0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_route", {instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o},
            (e.owner == ARB_DATA) ? {2'b01, 32'h0, e.data} : {2'b10, e.data, 32'h0});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[6];
    vec_t        v;
    arb_master_e w;
    logic [69:0] ef;

    tbl[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b1, 1'b1, ARB_INSTR, 1'b1};
    tbl[1] = '{1'b0, 32'h0,   1'b1, 1'b1, 4'h3, 32'h200, 32'hDEAD_BEEF, 1'b1, 1'b1, ARB_DATA,  1'b1};
    tbl[2] = '{1'b1, 32'h104, 1'b1, 1'b0, 4'hF, 32'h300, 32'hFFFF_FFFF, 1'b1, 1'b1, ARB_DATA,  1'b1};
    tbl[3] = '{1'b1, 32'h108, 1'b1, 1'b1, 4'hC, 32'h304, 32'h1234_5678, 1'b0, 1'b1, ARB_DATA,  1'b0};
    tbl[4] = '{1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b1, 1'b0, ARB_INSTR, 1'b0};
    tbl[5] = '{1'b0, 32'h0,   1'b1, 1'b0, 4'h1, 32'h40C, 32'h0,         1'b0, 1'b1, ARB_DATA,  1'b0};

    drive_idle();
    mem_rvalid_i = 0; mem_rdata_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_outs", all_outs(), '0);
    @(negedge clk_i);
    arstn_i = 1; auto_rsp = 1;
    next();

    for (int i = 0; i < 6; i++) begin
      v = tbl[i];
      w = v.e_win;
`ifdef MIRISCV_ARB_RR_EN
      if (v.ireq && v.dreq) w = (rr_last == ARB_INSTR) ? ARB_DATA : ARB_INSTR;
`endif
      instr_req_i = v.ireq; instr_addr_i = v.iaddr; data_req_i = v.dreq; data_we_i = v.dwe;
      data_be_i = v.dbe; data_addr_i = v.daddr; data_wdata_i = v.dwdata; mem_gnt_i = v.mgnt;
      if (v.e_req && v.e_gnt) begin
        push_exp(w, rsp_fn(w == ARB_DATA ? v.daddr : v.iaddr));
        rr_last = w;
      end
      sample();
      ef = !v.e_req ? '0 : (w == ARB_DATA) ? {1'b1, v.dwe, v.dbe, v.daddr, v.dwdata}
                                           : {1'b1, 1'b0, 4'hF, v.iaddr, 32'h0};
      chk($sformatf("vec%0d_mem", i), {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, ef);
      chk($sformatf("vec%0d_gnt", i), {instr_gnt_o, data_gnt_o},
          {v.e_gnt && w == ARB_INSTR, v.e_gnt && w == ARB_DATA});
      next(); drive_idle(); next(); next();
    end

    // Both sides held: data four times, then fetch forced in.
    instr_req_i = 1; instr_addr_i = 32'h500; data_req_i = 1; data_be_i = 4'hF;
    data_addr_i = 32'h600; mem_gnt_i = 1;
    for (int k = 0; k < 10; k++) begin
`ifdef MIRISCV_ARB_RR_EN
      w = (rr_last == ARB_INSTR) ? ARB_DATA : ARB_INSTR;
`else
      w = (k % 5 == 4) ? ARB_INSTR : ARB_DATA;
`endif
      push_exp(w, rsp_fn(w == ARB_DATA ? 32'h600 : 32'h500));
      rr_last = w;
      sample();
      chk($sformatf("starve_gnt%0d", k), {instr_gnt_o, data_gnt_o}, {w == ARB_INSTR, w == ARB_DATA});
      next();
    end
    drive_idle(); next(); next();
    sample(); auto_rsp = 0; next();

    // Fetch then data write, responses returned in order.
    instr_req_i = 1; instr_addr_i = 32'h100; mem_gnt_i = 1;
    push_exp(ARB_INSTR, 32'hAAAA_0001);
    sample();
    chk("t2_fetch_fields", {mem_req_o, mem_we_o, mem_be_o, mem_addr_o}, {1'b1, 1'b0, 4'hF, 32'h100});
    chk("t2_fetch_gnt", {instr_gnt_o, data_gnt_o}, 2'b10);
    next();
    instr_req_i = 0; instr_addr_i = 0; data_req_i = 1; data_we_i = 1; data_be_i = 4'b0011;
    data_addr_i = 32'h200; data_wdata_i = 32'h0BAD_F00D;
    push_exp(ARB_DATA, 32'h0);
    sample();
    chk("t2_data_gnt", {data_gnt_o, mem_we_o, mem_be_o, mem_addr_o}, {1'b1, 1'b1, 4'h3, 32'h200});
    next(); drive_idle(); mem_rvalid_i = 1; mem_rdata_i = 32'hAAAA_0001;
    sample();
    next(); mem_rdata_i = 32'h0;
    sample();
    next(); mem_rvalid_i = 0;

    // FIFO full after two reads; a pop does not free a slot in the same cycle.
    data_req_i = 1; data_addr_i = 32'hA0; data_be_i = 4'hF; mem_gnt_i = 1;
    push_exp(ARB_DATA, 32'h1111_0000);
    sample(); chk("t3_gnt0", data_gnt_o, 1'b1);
    next(); data_addr_i = 32'hA4; push_exp(ARB_DATA, 32'h2222_0000);
    sample(); chk("t3_gnt1", data_gnt_o, 1'b1);
    next(); data_addr_i = 32'hA8;
    sample(); chk("t3_full_block", {mem_req_o, data_gnt_o}, 2'b00);
    next(); mem_rvalid_i = 1; mem_rdata_i = 32'h1111_0000;
    sample(); chk("t3_no_same_cycle", {mem_req_o, data_gnt_o}, 2'b00);
    next(); mem_rvalid_i = 0; mem_rdata_i = 0; push_exp(ARB_DATA, 32'h3333_0000);
    sample(); chk("t3_third_issue", {mem_req_o, data_gnt_o, mem_addr_o}, {2'b11, 32'hA8});
    next(); drive_idle(); mem_rvalid_i = 1; mem_rdata_i = 32'h2222_0000;
    sample();
    next(); mem_rdata_i = 32'h3333_0000;
    sample();
    next(); mem_rvalid_i = 0; mem_rdata_i = 0;

    // Downstream stall: fields stable, no grant, exactly one entry after acceptance.
    data_req_i = 1; data_we_i = 1; data_be_i = 4'hC; data_addr_i = 32'h7C0;
    data_wdata_i = 32'hCAFE_0001; mem_gnt_i = 0;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk($sformatf("t4_stall%0d", k),
          {mem_req_o, data_gnt_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o},
          {1'b1, 1'b0, 1'b1, 4'hC, 32'h7C0, 32'hCAFE_0001});
      next();
    end
    mem_gnt_i = 1; push_exp(ARB_DATA, 32'h4444_0000);
    sample(); chk("t4_gnt", data_gnt_o, 1'b1);
    next(); drive_idle(); mem_rvalid_i = 1; mem_rdata_i = 32'h4444_0000;
    sample(); chk("t4_err_clear", arb_err_o, 1'b0);
    next(); mem_rdata_i = 32'h5555_0000;
    sample(); chk("t4_stray_drop", {instr_rvalid_o, data_rvalid_o}, 2'b00);
    next(); mem_rvalid_i = 0; mem_rdata_i = 0;
    sample(); chk("t4_stray_err", arb_err_o, 1'b1);
    chk("t4_sb_drained", exp_q.size(), 0);

    // Reset with two transactions outstanding: later responses are strays.
    next(); data_req_i = 1; data_addr_i = 32'h800; data_be_i = 4'hF; mem_gnt_i = 1;
    sample(); chk("t6_gnt0", data_gnt_o, 1'b1);
    next(); data_addr_i = 32'h804;
    sample(); chk("t6_gnt1", data_gnt_o, 1'b1);
    next(); drive_idle();
    #1 arstn_i = 0;
    #1 chk("t6_reset_outs", all_outs(), '0);
    @(negedge clk_i); arstn_i = 1;
    next(); mem_rvalid_i = 1; mem_rdata_i = 32'h9999_0000;
    sample(); chk("t6_stray0", {instr_rvalid_o, data_rvalid_o}, 2'b00);
    next();
    sample(); chk("t6_stray1", {instr_rvalid_o, data_rvalid_o}, 2'b00);
    chk("t6_err", arb_err_o, 1'b1);
    next(); mem_rvalid_i = 0; mem_rdata_i = 0;

    // Stray response right after reset: sticky error until the next reset.
    arstn_i = 0;
    #2 arstn_i = 1;
    chk("t5_err_rst", arb_err_o, 1'b0);
    mem_rvalid_i = 1; mem_rdata_i = 32'h7777_0000;
    sample();
    chk("t5_no_rsp", {instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o}, '0);
    chk("t5_err_pre", arb_err_o, 1'b0);
    next(); mem_rvalid_i = 0; mem_rdata_i = 0;
    for (int k = 0; k < 3; k++) begin
      sample(); chk($sformatf("t5_err_sticky%0d", k), arb_err_o, 1'b1);
      next();
    end
    arstn_i = 0;
    #1 chk("t5_err_reset", arb_err_o, 1'b0);
    @(negedge clk_i); arstn_i = 1;
    next();

    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
